// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared constants and types for the Viterbi decoder survivor-memory path.
//   DEPTH   : survivor bank depth in trellis steps (power of two)
//   ADDR_W  : bank address width, log2(DEPTH)
//   NBANK   : number of survivor banks in the rotation
//   TB_OFS  : traceback bank sits this many banks behind the write bank
//   DEC_OFS : decode bank sits this many banks behind the write bank
//   state_t : bank scheduler state
package viterbi_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NBANK  = 4;

  localparam logic [1:0] TB_OFS  = 2'd1;
  localparam logic [1:0] DEC_OFS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAD,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/trellis_sched_if.sv
// trellis_sched_if
// Bundle between the ACS side and the survivor-bank scheduler.
//   in_valid / in_last        : selection-vector strobe and end-of-frame mark
//   wr_en / wr_addr / pad     : survivor bank write side
//   tb_valid/tb_bank/tb_addr/tb_start   : traceback read side
//   dec_valid/dec_bank/dec_addr/dec_zero: decode read side
//   busy / done               : frame status
// Modports: master = ACS/control side, slave = scheduler.
interface trellis_sched_if
  import viterbi_pkg::*;
#(
  parameter int ADDR_W = viterbi_pkg::ADDR_W
);

  logic              in_valid;
  logic              in_last;
  logic [NBANK-1:0]  wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              pad;
  logic              tb_valid;
  logic [1:0]        tb_bank;
  logic [ADDR_W-1:0] tb_addr;
  logic              tb_start;
  logic              dec_valid;
  logic [1:0]        dec_bank;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_zero;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, in_last,
    input  wr_en, wr_addr, pad,
    input  tb_valid, tb_bank, tb_addr, tb_start,
    input  dec_valid, dec_bank, dec_addr, dec_zero,
    input  busy, done
  );

  modport slave (
    input  in_valid, in_last,
    output wr_en, wr_addr, pad,
    output tb_valid, tb_bank, tb_addr, tb_start,
    output dec_valid, dec_bank, dec_addr, dec_zero,
    output busy, done
  );

endinterface

// File: rtl/trellis_sched.sv
// trellis_sched
// Bank scheduler for the four-bank survivor memory. Counts selection vectors,
// rotates the write bank, issues one traceback read (newest complete bank) and
// one decode read (the bank before it) per step, and runs the end-of-frame
// flush: pad the partial bank, final traceback epoch, final decode epoch.
// Ports:
//   clk  : system clock
//   RST  : synchronous active-high reset
//   bus  : trellis_sched_if.slave (inputs in_valid/in_last, all other
//          signals are registered outputs, valid one cycle after their step)
module trellis_sched #(
  parameter int DEPTH  = viterbi_pkg::DEPTH,
  parameter int ADDR_W = viterbi_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             RST,
  trellis_sched_if.slave   bus
);
  import viterbi_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Frame position state
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_cnt_reg, wr_cnt_next;
  logic [1:0]        wr_bank_reg, wr_bank_next;
  logic [1:0]        banks_done_reg, banks_done_next;
  logic [1:0]        flush_ep_reg, flush_ep_next;

  // Registered outputs
  logic [NBANK-1:0]  wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic              pad_reg, pad_next;
  logic              tb_valid_reg, tb_valid_next;
  logic [1:0]        tb_bank_reg, tb_bank_next;
  logic [ADDR_W-1:0] tb_addr_reg, tb_addr_next;
  logic              tb_start_reg, tb_start_next;
  logic              dec_valid_reg, dec_valid_next;
  logic [1:0]        dec_bank_reg, dec_bank_next;
  logic [ADDR_W-1:0] dec_addr_reg, dec_addr_next;
  logic              dec_zero_reg, dec_zero_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic [NBANK-1:0]  bank_onehot;
  logic              at_last;
  logic [ADDR_W-1:0] rd_addr;
  logic              write_step;

  // One-hot decode of the current write bank
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_onehot
    assign bank_onehot[gi] = (wr_bank_reg == 2'(gi));
  end

  assign at_last = (wr_cnt_reg == LAST_ADDR);
  // Reads walk each bank backwards while writes walk forwards
  assign rd_addr = LAST_ADDR - wr_cnt_reg;

  always_comb begin
    state_next      = state_reg;
    wr_cnt_next     = wr_cnt_reg;
    wr_bank_next    = wr_bank_reg;
    banks_done_next = banks_done_reg;
    flush_ep_next   = flush_ep_reg;
    wr_en_next      = '0;
    wr_addr_next    = '0;
    pad_next        = 1'b0;
    tb_valid_next   = 1'b0;
    tb_bank_next    = '0;
    tb_addr_next    = '0;
    tb_start_next   = 1'b0;
    dec_valid_next  = 1'b0;
    dec_bank_next   = '0;
    dec_addr_next   = '0;
    dec_zero_next   = 1'b0;
    done_next       = 1'b0;
    write_step      = 1'b0;

    case (state_reg)
      IDLE, RUN: begin
        if (bus.in_valid) begin
          write_step = 1'b1;
          if (bus.in_last) begin
            // A frame ending exactly on a bank boundary needs no padding
            state_next = at_last ? DRAIN : PAD;
          end else begin
            state_next = RUN;
          end
        end
      end

      PAD: begin
        write_step = 1'b1;
        pad_next   = 1'b1;
        if (at_last) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        // Bank rotation is frozen here: the last written bank stays at
        // wr_bank-1 for both flush epochs.
        wr_cnt_next = wr_cnt_reg + ADDR_W'(1);
        if (flush_ep_reg == 2'd0) begin
          tb_valid_next  = (banks_done_reg != 2'd0);
          dec_valid_next = (banks_done_reg == 2'd2);
          if (at_last) begin
            if (banks_done_reg != 2'd0) begin
              flush_ep_next = 2'd1;
            end else begin
              state_next = DONE;
            end
          end
        end else begin
          // Final bank: terminated code, so decode starts from state 0
          dec_valid_next = 1'b1;
          dec_zero_next  = 1'b1;
          if (at_last) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        done_next       = 1'b1;
        state_next      = IDLE;
        wr_cnt_next     = '0;
        wr_bank_next    = '0;
        banks_done_next = '0;
        flush_ep_next   = '0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (write_step) begin
      wr_en_next     = bank_onehot;
      wr_addr_next   = wr_cnt_reg;
      tb_valid_next  = (banks_done_reg != 2'd0);
      dec_valid_next = (banks_done_reg == 2'd2);
      wr_cnt_next    = wr_cnt_reg + ADDR_W'(1);
      if (at_last) begin
        wr_bank_next = wr_bank_reg + 2'd1;
        if (banks_done_reg != 2'd2) begin
          banks_done_next = banks_done_reg + 2'd1;
        end
      end
    end

    if (tb_valid_next) begin
      tb_bank_next  = wr_bank_reg - TB_OFS;
      tb_addr_next  = rd_addr;
      tb_start_next = (wr_cnt_reg == '0);
    end

    if (dec_valid_next) begin
      dec_addr_next = rd_addr;
      dec_bank_next = dec_zero_next ? (wr_bank_reg - TB_OFS)
                                    : (wr_bank_reg - DEC_OFS);
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg      <= IDLE;
      wr_cnt_reg     <= '0;
      wr_bank_reg    <= '0;
      banks_done_reg <= '0;
      flush_ep_reg   <= '0;
      wr_en_reg      <= '0;
      wr_addr_reg    <= '0;
      pad_reg        <= 1'b0;
      tb_valid_reg   <= 1'b0;
      tb_bank_reg    <= '0;
      tb_addr_reg    <= '0;
      tb_start_reg   <= 1'b0;
      dec_valid_reg  <= 1'b0;
      dec_bank_reg   <= '0;
      dec_addr_reg   <= '0;
      dec_zero_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_cnt_reg     <= wr_cnt_next;
      wr_bank_reg    <= wr_bank_next;
      banks_done_reg <= banks_done_next;
      flush_ep_reg   <= flush_ep_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      pad_reg        <= pad_next;
      tb_valid_reg   <= tb_valid_next;
      tb_bank_reg    <= tb_bank_next;
      tb_addr_reg    <= tb_addr_next;
      tb_start_reg   <= tb_start_next;
      dec_valid_reg  <= dec_valid_next;
      dec_bank_reg   <= dec_bank_next;
      dec_addr_reg   <= dec_addr_next;
      dec_zero_reg   <= dec_zero_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.pad       = pad_reg;
  assign bus.tb_valid  = tb_valid_reg;
  assign bus.tb_bank   = tb_bank_reg;
  assign bus.tb_addr   = tb_addr_reg;
  assign bus.tb_start  = tb_start_reg;
  assign bus.dec_valid = dec_valid_reg;
  assign bus.dec_bank  = dec_bank_reg;
  assign bus.dec_addr  = dec_addr_reg;
  assign bus.dec_zero  = dec_zero_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_trellis_sched.sv
// tb_trellis_sched
// Directed/randomised bench for trellis_sched. The reference model tracks the
// frame only as "number of symbols written" and "flush step index", and derives
// every expected output from those with plain arithmetic.
module tb_trellis_sched;

  localparam int D = 32;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAD   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  typedef struct {
    logic [3:0] wr_en;
    logic [4:0] wr_addr;
    logic       pad;
    logic       tb_valid;
    logic [1:0] tb_bank;
    logic [4:0] tb_addr;
    logic       tb_start;
    logic       dec_valid;
    logic [1:0] dec_bank;
    logic [4:0] dec_addr;
    logic       dec_zero;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  trellis_sched_if bus ();

  trellis_sched dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  // Reference model state
  int ph = P_IDLE;
  int n  = 0;   // symbols (incl. padding) written in this frame
  int j  = 0;   // flush step index, 0 .. 2*D-1

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t zero_rec();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Write step number k of the frame (0-based)
  function automatic exp_t write_rec(input int k, input bit is_pad);
    exp_t e;
    int b, a;
    e = '{default: '0};
    b = k / D;
    a = k % D;
    e.wr_en     = 4'(1 << (b % 4));
    e.wr_addr   = 5'(a);
    e.pad       = is_pad;
    e.tb_valid  = (b >= 1);
    e.dec_valid = (b >= 2);
    e.tb_bank   = 2'((b + 3) % 4);
    e.dec_bank  = 2'((b + 2) % 4);
    e.tb_addr   = 5'(D - 1 - a);
    e.dec_addr  = 5'(D - 1 - a);
    e.tb_start  = (b >= 1) && (a == 0);
    return e;
  endfunction

  // Flush step s after a frame of 'total' written entries (multiple of D)
  function automatic exp_t drain_rec(input int total, input int s);
    exp_t e;
    int nb, lb;
    e = '{default: '0};
    nb = total / D;
    lb = (nb - 1) % 4;
    if (s < D) begin
      e.tb_valid  = 1'b1;
      e.tb_bank   = 2'(lb);
      e.tb_addr   = 5'(D - 1 - s);
      e.tb_start  = (s == 0);
      e.dec_valid = (nb >= 2);
      e.dec_bank  = 2'((lb + 3) % 4);
      e.dec_addr  = 5'(D - 1 - s);
    end else begin
      e.dec_valid = 1'b1;
      e.dec_zero  = 1'b1;
      e.dec_bank  = 2'(lb);
      e.dec_addr  = 5'(D - 1 - (s - D));
    end
    return e;
  endfunction

  task automatic cmp(input exp_t e);
    chk("wr_en",     32'(bus.wr_en),     32'(e.wr_en));
    chk("pad",       32'(bus.pad),       32'(e.pad));
    chk("tb_valid",  32'(bus.tb_valid),  32'(e.tb_valid));
    chk("tb_start",  32'(bus.tb_start),  32'(e.tb_start));
    chk("dec_valid", 32'(bus.dec_valid), 32'(e.dec_valid));
    chk("dec_zero",  32'(bus.dec_zero),  32'(e.dec_zero));
    chk("busy",      32'(bus.busy),      32'(e.busy));
    chk("done",      32'(bus.done),      32'(e.done));
    if (e.wr_en != 4'd0) chk("wr_addr", 32'(bus.wr_addr), 32'(e.wr_addr));
    if (e.tb_valid) begin
      chk("tb_bank", 32'(bus.tb_bank), 32'(e.tb_bank));
      chk("tb_addr", 32'(bus.tb_addr), 32'(e.tb_addr));
    end
    if (e.dec_valid) begin
      chk("dec_bank", 32'(bus.dec_bank), 32'(e.dec_bank));
      chk("dec_addr", 32'(bus.dec_addr), 32'(e.dec_addr));
    end
  endtask

  // One clock with RST low: drive, advance model, compare after the edge
  task automatic cyc(input bit v, input bit l);
    exp_t e;
    e = zero_rec();
    bus.in_valid = v;
    bus.in_last  = l;
    case (ph)
      P_IDLE, P_RUN: begin
        if (v) begin
          e = write_rec(n, 1'b0);
          n++;
          if (l) begin
            if (n % D == 0) begin
              ph = P_DRAIN;
              j  = 0;
            end else begin
              ph = P_PAD;
            end
          end else begin
            ph = P_RUN;
          end
        end
      end
      P_PAD: begin
        e = write_rec(n, 1'b1);
        n++;
        if (n % D == 0) begin
          ph = P_DRAIN;
          j  = 0;
        end
      end
      P_DRAIN: begin
        e = drain_rec(n, j);
        j++;
        if (j == 2 * D) ph = P_DONE;
      end
      default: begin
        e.done = 1'b1;
        ph     = P_IDLE;
        n      = 0;
      end
    endcase
    e.busy = (ph != P_IDLE);
    @(posedge clk);
    #1;
    cmp(e);
  endtask

  task automatic rst_cycles(input int c, input bit v);
    RST          = 1'b1;
    bus.in_valid = v;
    bus.in_last  = 1'b0;
    for (int i = 0; i < c; i++) begin
      @(posedge clk);
      #1;
      cmp(zero_rec());
    end
    RST = 1'b0;
    ph  = P_IDLE;
    n   = 0;
    j   = 0;
  endtask

  // Let pad/flush run out while upstream noise on in_valid is ignored
  task automatic run_flush(input string name);
    int k;
    int wrote;
    wrote = n;
    k = 0;
    while ((ph != P_IDLE || bus.busy === 1'b1) && k < 400) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      k++;
    end
    chk({name, "_end_busy"}, 32'(bus.busy), 32'd0);
    frames++;
    $display("frame %0d %s: entries_at_last=%0d flush_cycles=%0d checks=%0d failures=%0d",
             frames, name, wrote, k, checks, failures);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Reset held 3 cycles with in_valid high; then one idle cycle
    rst_cycles(3, 1'b1);
    cyc(1'b0, 1'b0);

    // Steady fill, then 1/0 gaps, then random gaps across several bank wraps
    for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'(i % 2 == 0), 1'b0);
    while (n < 170) cyc(1'($urandom_range(0, 3) != 0), 1'b0);
    cyc(1'b1, 1'b1);
    run_flush("rotation");

    // Unaligned end on step 40 (bank 1, wr_cnt 7)
    for (int i = 0; i < 39; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    run_flush("unaligned");

    // Frame ending exactly on a bank boundary, random gaps
    while (n < 2 * D - 1) cyc(1'($urandom_range(0, 1)), 1'b0);
    cyc(1'b1, 1'b1);
    run_flush("aligned");

    // One-symbol frame from IDLE
    cyc(1'b1, 1'b1);
    run_flush("single");

    // Reset during flush epoch 0, then a fresh frame from bank 0 address 0
    for (int i = 0; i < D - 1; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
    rst_cycles(1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    run_flush("after_reset");

    // Random frames with random lengths and gaps
    for (int f = 0; f < 3; f++) begin
      int len;
      len = int'($urandom_range(1, 110));
      while (n < len - 1) cyc(1'($urandom_range(0, 2) != 0), 1'b0);
      cyc(1'b1, 1'b1);
      run_flush("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trellis_sched.md
# trellis_sched

Bank scheduler for the four-bank, 32-deep survivor (trellis) memory of the Viterbi decoder. It sits between the ACS unit and the survivor memory banks. It counts incoming selection vectors and rotates the write bank, and it schedules two reads per cycle: a traceback read of the newest complete bank and a decode read of the bank before it. It also runs the end-of-frame flush: pad, final traceback, final decode.

## Interface
Parameters:
- DEPTH, 32, survivor bank depth in trellis steps. Must be a power of two.
- ADDR_W, 5, address width. Equals log2(DEPTH).

Ports:
- clk  in  1  system clock. Single clock domain.
- RST  in  1  reset. Synchronous, active-high.
- in_valid  in  1  ACS has a selection vector this cycle.
- in_last  in  1  qualifies in_valid. Marks the last symbol of the frame.
- wr_en  out  4  one-hot write enable, bit i = bank i.
- wr_addr  out  ADDR_W  write address.
- pad  out  1  current write is flush padding. Datapath writes zeros.
- tb_valid  out  1  traceback read active.
- tb_bank  out  2  traceback bank.
- tb_addr  out  ADDR_W  traceback address.
- tb_start  out  1  first traceback read of an epoch (address DEPTH-1).
- dec_valid  out  1  decode read active.
- dec_bank  out  2  decode bank.
- dec_addr  out  ADDR_W  decode address.
- dec_zero  out  1  decode epoch starts from state 0 (final bank, terminated code).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the frame is fully decoded.

## Operation
- Internal counters:
  - wr_cnt (ADDR_W bits)
  - wr_bank (2 bits)
  - banks_done (saturates at 2)
  - flush_ep (2 bits)
- A step is one cycle in which the counters advance:
  - IDLE and RUN: a step happens on in_valid.
  - PAD and DRAIN: every cycle is a step.
  - A cycle with no step holds every counter. All valid and enable outputs are 0 on that cycle.
- Per step:
  - wr_addr = wr_cnt; wr_en = 1 << wr_bank (suppressed in DRAIN).
  - tb_addr = dec_addr = DEPTH-1-wr_cnt.
  - tb_bank = wr_bank-1; dec_bank = wr_bank-2 (mod 4). Bank wr_bank-3 is idle.
  - tb_valid = (banks_done ≥ 1).
  - dec_valid = (banks_done ≥ 2).
  - tb_start = tb_valid && wr_cnt == 0.
- Wrap: a step with wr_cnt == DEPTH-1 sets wr_cnt to 0, increments wr_bank (3 → 0) and increments banks_done (saturating).
- States:
  - IDLE → RUN on the first in_valid. That step already writes bank 0, address 0.
  - RUN → PAD on in_valid && in_last when wr_cnt ≠ DEPTH-1. The last-symbol step is a normal write.
  - RUN → DRAIN on in_valid && in_last when wr_cnt == DEPTH-1 (the frame ends on a bank boundary).
  - PAD: one padding write per cycle with pad=1, until the write with wr_cnt == DEPTH-1; then → DRAIN.
  - DRAIN: epoch 0 (flush_ep=0) runs DEPTH steps with no writes. Traceback reads bank wr_bank-1 and decode reads bank wr_bank-2, as in RUN.
  - DRAIN: epoch 1 runs DEPTH steps with no writes and no traceback. Decode reads bank wr_bank-1 with dec_zero=1. It is skipped when banks_done < 1.
  - DRAIN end → DONE, then → IDLE on the next cycle with done=1. All counters clear.
- In PAD and DRAIN, in_valid is ignored. The upstream block must hold off; violations are not buffered.
- In IDLE, in_last with in_valid ends a 1-symbol frame: → PAD.

## Timing
- Every output is registered and appears one cycle after the step that produces it.
- Reset values: every output is 0; wr_bank=0, wr_cnt=0, state IDLE.
- RST takes priority over every other input. Asserting RST mid-frame returns to IDLE the next cycle with all outputs 0. Partial banks are abandoned.
- Throughput: one selection vector per cycle, with no back-pressure in RUN.
- Latency from the final in_valid to done:
  - Frame ending on a bank boundary: 2·DEPTH + 2 cycles, assuming banks_done ≥ 1.
  - Otherwise, add the padding cycles.
- Decode read data emerges in reverse order within a bank. Reordering is the downstream LIFO's job.

## Structure
- Shared package viterbi_pkg holds:
  - DEPTH, ADDR_W, NBANK=4
  - the state enum: IDLE, RUN, PAD, DRAIN, DONE
  - the bank-offset constants (TB_OFS=1, DEC_OFS=2)
- Single module, no sub-modules. The counter/bank logic is too small to split out.

## Test plan
- Reset: hold RST 3 cycles, with in_valid=1 during reset → all outputs 0 and busy=0; the first post-reset cycle stays idle.
- Steady fill: 70 back-to-back in_valid, no in_last →
  - wr_en=0001, addr 0..31
  - then 0010: tb_bank=0, tb_addr 31..0, tb_start on the first of those cycles, dec_valid=0
  - from step 64: wr_en=0100, tb_bank=1, dec_bank=0, dec_valid=1
- Gaps: 40 steps with in_valid toggling 1,0 → counters hold on the 0 cycles, addresses are contiguous, and all valids are 0 on the gap cycles.
- Bank rotation: 160 steps → wr_bank sequence 0,1,2,3,0; dec_bank always equals wr_bank-2 mod 4.
- Unaligned end: in_last on step 40 (wr_cnt=7, bank 1) →
  - 24 pad cycles with pad=1
  - 32 cycles: tb_bank=1, dec_bank=0
  - 32 cycles: dec_bank=1 with dec_zero=1
  - DONE, then done pulses once; busy falls.
- Reset mid-DRAIN: assert RST during epoch 0 → next cycle all outputs 0; a new frame then starts at bank 0, address 0.
